// File: rtl/axi_master_write.sv
// axi_master_write: issues one AXI4 INCR write burst (64-bit beats, 1..MAX_LEN beats) per user trigger, data from a FWFT FIFO.
// Latency: start sampled at edge N -> aw_valid high after edge N+2; one W beat per cycle; wr_fifo_done one cycle after the B handshake.
// Backpressure: aw_ready/w_ready stall the burst; an empty FIFO drops w_valid (no timeout); starts while busy are ignored.
//
// Build option: define AXI_WR_BRESP_CHECK_EN to report a non-OKAY b_resp on wr_err.
// Without it, wr_err is tied low and b_resp is ignored. The state flow is the same in both builds.
//
// Ports:
//   axi_clk, axi_rst         clock, asynchronous active-high reset
//   m_axi_aw_*               write address channel (registered addr/len/valid, constant attributes)
//   m_axi_w_*                write data channel (data straight from the FIFO head, strobes all ones)
//   m_axi_b_*                write response channel (b_id ignored)
//   wr_start/wr_adrs/wr_len  burst request, sampled only while wr_ready is high
//   wr_ready                 high while idle
//   wr_fifo_empty/data/re    show-ahead FIFO interface, wr_fifo_re pops on each accepted beat
//   wr_fifo_done, wr_err     one-cycle completion pulse, plus error flag in the same cycle
module axi_master_write #(
    parameter logic [3:0] AXI_ID  = 4'b1111,
    parameter int         MAX_LEN = 256
) (
    input  logic        axi_clk,
    input  logic        axi_rst,

    output logic [3:0]  m_axi_aw_id,
    output logic [31:0] m_axi_aw_addr,
    output logic [7:0]  m_axi_aw_len,
    output logic [2:0]  m_axi_aw_size,
    output logic [1:0]  m_axi_aw_burst,
    output logic [1:0]  m_axi_aw_lock,
    output logic [3:0]  m_axi_aw_cache,
    output logic [2:0]  m_axi_aw_prot,
    output logic [3:0]  m_axi_aw_qos,
    output logic        m_axi_aw_valid,
    input  logic        m_axi_aw_ready,

    output logic [63:0] m_axi_w_data,
    output logic [7:0]  m_axi_w_strb,
    output logic        m_axi_w_last,
    output logic        m_axi_w_valid,
    input  logic        m_axi_w_ready,

    input  logic [3:0]  m_axi_b_id,
    input  logic [1:0]  m_axi_b_resp,
    input  logic        m_axi_b_valid,
    output logic        m_axi_b_ready,

    input  logic        wr_start,
    input  logic [31:0] wr_adrs,
    input  logic [9:0]  wr_len,
    output logic        wr_ready,

    input  logic        wr_fifo_empty,
    input  logic [63:0] wr_fifo_data,
    output logic        wr_fifo_re,
    output logic        wr_fifo_done,
    output logic        wr_err
);

    typedef enum logic [2:0] {
        S_WR_IDLE,
        S_WA_WAIT,
        S_WA_START,
        S_WA_HOLD,
        S_WD_PROC,
        S_WR_RESP,
        S_WR_DONE
    } state_t;

    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    state_t      state;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;     // wr_len - 1, also the index of the final beat
    logic [7:0]  beat_cnt;
    logic        aw_valid_q;
    logic        b_ready_q;
    logic        done_q;
    logic        ready_q;

    logic        len_ok;
    logic        w_valid;
    logic        w_last;
    logic        beat;

    // A request is only taken when its length fits the 8-bit AWLEN encoding.
    assign len_ok  = (wr_len != 10'd0) && ({1'b0, wr_len} <= MAX_LEN_W);

    // W is only offered in the data state, so data can never precede the AW handshake.
    assign w_valid = (state == S_WD_PROC) && !wr_fifo_empty;
    assign w_last  = w_valid && (beat_cnt == aw_len_q);
    assign beat    = w_valid && m_axi_w_ready;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state      <= S_WR_IDLE;
            aw_addr_q  <= 32'd0;
            aw_len_q   <= 8'd0;
            beat_cnt   <= 8'd0;
            aw_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_WR_IDLE: begin
                    if (wr_start && len_ok) begin
                        aw_addr_q <= wr_adrs;
                        // 256 beats wraps to 0 here, so the subtraction yields 8'hFF as required.
                        aw_len_q  <= wr_len[7:0] - 8'd1;
                        beat_cnt  <= 8'd0;
                        ready_q   <= 1'b0;
                        state     <= S_WA_WAIT;
                    end
                end
                S_WA_WAIT: begin
                    state <= S_WA_START;
                end
                S_WA_START: begin
                    aw_valid_q <= 1'b1;
                    state      <= S_WA_HOLD;
                end
                S_WA_HOLD: begin
                    if (m_axi_aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state      <= S_WD_PROC;
                    end
                end
                S_WD_PROC: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (w_last) begin
                            b_ready_q <= 1'b1;
                            state     <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_b_valid) begin
                        b_ready_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_WR_DONE;
                    end
                end
                S_WR_DONE: begin
                    ready_q <= 1'b1;
                    state   <= S_WR_IDLE;
                end
                default: begin
                    state <= S_WR_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_WR_BRESP_CHECK_EN
    // Error flag is captured with the B handshake so it lines up with the done pulse.
    logic err_q;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            err_q <= 1'b0;
        end else if ((state == S_WR_RESP) && m_axi_b_valid) begin
            err_q <= (m_axi_b_resp != 2'b00);
        end else begin
            err_q <= 1'b0;
        end
    end

    assign wr_err = err_q;

    logic unused_b_id;
    assign unused_b_id = ^m_axi_b_id;
`else
    assign wr_err = 1'b0;

    logic unused_b_fields;
    assign unused_b_fields = ^{m_axi_b_id, m_axi_b_resp};
`endif

    assign m_axi_aw_id    = AXI_ID;
    assign m_axi_aw_addr  = aw_addr_q;
    assign m_axi_aw_len   = aw_len_q;
    assign m_axi_aw_size  = 3'b011;
    assign m_axi_aw_burst = 2'b01;
    assign m_axi_aw_lock  = 2'b00;
    assign m_axi_aw_cache = 4'b0011;
    assign m_axi_aw_prot  = 3'b000;
    assign m_axi_aw_qos   = 4'b0000;
    assign m_axi_aw_valid = aw_valid_q;

    assign m_axi_w_data   = wr_fifo_data;
    assign m_axi_w_strb   = 8'hFF;
    assign m_axi_w_last   = w_last;
    assign m_axi_w_valid  = w_valid;

    assign m_axi_b_ready  = b_ready_q;

    assign wr_ready       = ready_q;
    assign wr_fifo_re     = beat;
    assign wr_fifo_done   = done_q;

endmodule

// File: tb/tb_axi_master_write.sv
// tb_axi_master_write: random and directed bursts against a timeline model of the write master.
// Latency: n/a (bench).
// Backpressure: the slave model randomises aw_ready/w_ready/b_valid and FIFO empty gaps.
`timescale 1ns/1ps
module tb_axi_master_write;

`ifdef AXI_WR_BRESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic [3:0]  m_axi_aw_id;
    logic [31:0] m_axi_aw_addr;
    logic [7:0]  m_axi_aw_len;
    logic [2:0]  m_axi_aw_size;
    logic [1:0]  m_axi_aw_burst;
    logic [1:0]  m_axi_aw_lock;
    logic [3:0]  m_axi_aw_cache;
    logic [2:0]  m_axi_aw_prot;
    logic [3:0]  m_axi_aw_qos;
    logic        m_axi_aw_valid;
    logic        m_axi_aw_ready;
    logic [63:0] m_axi_w_data;
    logic [7:0]  m_axi_w_strb;
    logic        m_axi_w_last;
    logic        m_axi_w_valid;
    logic        m_axi_w_ready;
    logic [3:0]  m_axi_b_id;
    logic [1:0]  m_axi_b_resp;
    logic        m_axi_b_valid;
    logic        m_axi_b_ready;
    logic        wr_start;
    logic [31:0] wr_adrs;
    logic [9:0]  wr_len;
    logic        wr_ready;
    logic        wr_fifo_empty;
    logic [63:0] wr_fifo_data;
    logic        wr_fifo_re;
    logic        wr_fifo_done;
    logic        wr_err;

    always #5 axi_clk = ~axi_clk;

    axi_master_write dut (
        .axi_clk        (axi_clk),
        .axi_rst        (axi_rst),
        .m_axi_aw_id    (m_axi_aw_id),
        .m_axi_aw_addr  (m_axi_aw_addr),
        .m_axi_aw_len   (m_axi_aw_len),
        .m_axi_aw_size  (m_axi_aw_size),
        .m_axi_aw_burst (m_axi_aw_burst),
        .m_axi_aw_lock  (m_axi_aw_lock),
        .m_axi_aw_cache (m_axi_aw_cache),
        .m_axi_aw_prot  (m_axi_aw_prot),
        .m_axi_aw_qos   (m_axi_aw_qos),
        .m_axi_aw_valid (m_axi_aw_valid),
        .m_axi_aw_ready (m_axi_aw_ready),
        .m_axi_w_data   (m_axi_w_data),
        .m_axi_w_strb   (m_axi_w_strb),
        .m_axi_w_last   (m_axi_w_last),
        .m_axi_w_valid  (m_axi_w_valid),
        .m_axi_w_ready  (m_axi_w_ready),
        .m_axi_b_id     (m_axi_b_id),
        .m_axi_b_resp   (m_axi_b_resp),
        .m_axi_b_valid  (m_axi_b_valid),
        .m_axi_b_ready  (m_axi_b_ready),
        .wr_start       (wr_start),
        .wr_adrs        (wr_adrs),
        .wr_len         (wr_len),
        .wr_ready       (wr_ready),
        .wr_fifo_empty  (wr_fifo_empty),
        .wr_fifo_data   (wr_fifo_data),
        .wr_fifo_re     (wr_fifo_re),
        .wr_fifo_done   (wr_fifo_done),
        .wr_err         (wr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ environment
    logic [63:0] fifo_q[$];
    logic [63:0] next_base = 64'd0;
    int          burst_no  = 1;
    int          aw_mode   = 0;   // 0: always ready, 1: random
    int          wr_mode   = 0;   // 0: always ready, 1: toggle, 2: random
    bit          rand_empty = 1'b0;
    logic [1:0]  resp_val  = 2'b00;
    bit          pending_b = 1'b0;
    bit          snap_pop, snap_last, snap_b;

    initial begin
        m_axi_aw_ready = 1'b0;
        m_axi_w_ready  = 1'b0;
        m_axi_b_valid  = 1'b0;
        m_axi_b_resp   = 2'b00;
        m_axi_b_id     = 4'h0;
        wr_fifo_empty  = 1'b1;
        wr_fifo_data   = 64'd0;
        forever begin
            @(negedge axi_clk);
            snap_pop  = wr_fifo_re;
            snap_last = m_axi_w_valid && m_axi_w_ready && m_axi_w_last;
            snap_b    = m_axi_b_valid && m_axi_b_ready;
            @(posedge axi_clk);
            #1;
            if (snap_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (axi_rst) begin
                pending_b = 1'b0;
            end else begin
                if (snap_b)    pending_b = 1'b0;
                if (snap_last) pending_b = 1'b1;
            end
            m_axi_aw_ready = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (wr_mode)
                0:       m_axi_w_ready = 1'b1;
                1:       m_axi_w_ready = ~m_axi_w_ready;
                default: m_axi_w_ready = 1'($urandom_range(0, 1));
            endcase
            if (snap_b || !pending_b) m_axi_b_valid = 1'b0;
            else if (!m_axi_b_valid)  m_axi_b_valid = ($urandom_range(0, 2) != 0);
            m_axi_b_resp = resp_val;
            m_axi_b_id   = 4'($urandom_range(0, 15));
            #1;
            wr_fifo_empty = (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 3) == 0));
            wr_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
        end
    end

    // ------------------------------------------------------------------ model + compare
    // Timeline model: a burst is a sequence of events (trigger, AW accept, N beats, B accept);
    // the expected outputs in each cycle follow from which events have happened and when.
    bit          m_busy = 1'b0, m_aw_acc = 1'b0, m_data = 1'b0, m_resp = 1'b0, m_errflag = 1'b0;
    int          cyc = 0, t_start = 0, t_bfire = -100, m_beats = 0, m_len = 0;
    logic [31:0] m_addr = 32'd0;
    logic [7:0]  m_awlen = 8'd0;
    logic [63:0] m_base = 64'd0;
    int          pops_cnt = 0, last_cnt = 0, aw_hs_cnt = 0, done_cnt = 0, err_cnt = 0, wv_cnt = 0;
    logic [31:0] last_awaddr = 32'd0;
    logic [7:0]  last_awlen  = 8'd0;

    initial begin : compare
        bit e_ready, e_awv, e_wv, e_last, e_re, e_bready, e_done, e_err;
        forever begin
            @(negedge axi_clk);
            cyc++;
            if (axi_rst) begin
                m_busy = 1'b0; m_aw_acc = 1'b0; m_data = 1'b0; m_resp = 1'b0;
                t_bfire = -100; m_addr = 32'd0; m_awlen = 8'd0;
            end
            e_ready  = !m_busy;
            e_awv    = m_busy && !m_aw_acc && (cyc >= t_start + 3);
            e_wv     = m_data && !wr_fifo_empty;
            e_last   = e_wv && (m_beats == m_len - 1);
            e_re     = e_wv && m_axi_w_ready;
            e_bready = m_resp;
            e_done   = (cyc == t_bfire + 1);
            e_err    = e_done && m_errflag && ERR_EN;

            chk("wr_ready",     64'(wr_ready),       64'(e_ready));
            chk("aw_valid",     64'(m_axi_aw_valid), 64'(e_awv));
            chk("aw_addr",      64'(m_axi_aw_addr),  64'(m_addr));
            chk("aw_len",       64'(m_axi_aw_len),   64'(m_awlen));
            chk("w_valid",      64'(m_axi_w_valid),  64'(e_wv));
            chk("w_last",       64'(m_axi_w_last),   64'(e_last));
            chk("wr_fifo_re",   64'(wr_fifo_re),     64'(e_re));
            chk("b_ready",      64'(m_axi_b_ready),  64'(e_bready));
            chk("wr_fifo_done", 64'(wr_fifo_done),   64'(e_done));
            chk("wr_err",       64'(wr_err),         64'(e_err));
            chk("w_data_path",  m_axi_w_data,        wr_fifo_data);
            chk("aw_constants",
                64'({m_axi_aw_id, m_axi_aw_size, m_axi_aw_burst, m_axi_aw_lock,
                     m_axi_aw_cache, m_axi_aw_prot, m_axi_aw_qos, m_axi_w_strb}),
                64'({4'hF, 3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 8'hFF}));

            if (!axi_rst) begin
                if (wr_fifo_re) pops_cnt++;
                if (m_axi_w_valid) wv_cnt++;
                if (m_axi_w_valid && m_axi_w_ready && m_axi_w_last) last_cnt++;
                if (m_axi_aw_valid && m_axi_aw_ready) begin
                    aw_hs_cnt++;
                    last_awaddr = m_axi_aw_addr;
                    last_awlen  = m_axi_aw_len;
                end
                if (wr_fifo_done) done_cnt++;
                if (wr_err) err_cnt++;

                if (e_bready && m_axi_b_valid) begin
                    m_resp    = 1'b0;
                    t_bfire   = cyc;
                    m_errflag = (m_axi_b_resp != 2'b00);
                end
                if (e_wv && m_axi_w_ready) begin
                    chk("w_data_order", m_axi_w_data, m_base + 64'(m_beats));
                    m_beats++;
                    if (e_last) begin
                        m_data = 1'b0;
                        m_resp = 1'b1;
                    end
                end
                if (e_awv && m_axi_aw_ready) begin
                    m_aw_acc = 1'b1;
                    m_data   = 1'b1;
                end
                if (e_done) m_busy = 1'b0;
                if (e_ready && wr_start && (wr_len != 10'd0) && (wr_len <= 10'd256)) begin
                    m_busy   = 1'b1;
                    t_start  = cyc;
                    m_aw_acc = 1'b0;
                    m_beats  = 0;
                    m_len    = int'(wr_len);
                    m_addr   = wr_adrs;
                    m_awlen  = 8'(int'(wr_len) - 1);
                    m_base   = next_base;
                end
            end
        end
    end

    // ------------------------------------------------------------------ stimulus
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(next_base + 64'(first + i));
    endtask

    task automatic start_burst(input logic [31:0] a, input int len, input int nwords);
        next_base = (64'(burst_no) << 32) | 64'h00C0_0000;
        burst_no++;
        push_words(0, nwords);
        wr_adrs  = a;
        wr_len   = 10'(len);
        wr_start = 1'b1;
        cyc_wait(1);
        wr_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc_wait(1);
        chk("burst_completes", 64'(done_cnt - d0), 64'd1);
        cyc_wait(1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int i = 0; i < budget && pops_cnt < target; i++) cyc_wait(1);
        chk("pops_reached", 64'(pops_cnt >= target), 64'd1);
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p0, l0, a0, e0, w0, d0, len;
        axi_rst  = 1'b1;
        wr_start = 1'b0;
        wr_adrs  = 32'd0;
        wr_len   = 10'd0;
        cyc_wait(3);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_aw_valid", 64'(m_axi_aw_valid), 64'd0);
        axi_rst = 1'b0;
        cyc_wait(2);

        // single beat
        p0 = pops_cnt; l0 = last_cnt; e0 = err_cnt;
        start_burst(32'h0000_1000, 1, 1);
        wait_done(100);
        chk("single_aw_len",  64'(last_awlen),  64'h00);
        chk("single_aw_addr", 64'(last_awaddr), 64'h1000);
        chk("single_pops",    64'(pops_cnt - p0), 64'd1);
        chk("single_last",    64'(last_cnt - l0), 64'd1);
        chk("single_err",     64'(err_cnt - e0),  64'd0);

        // full burst, w_ready toggling
        wr_mode = 1;
        p0 = pops_cnt; l0 = last_cnt;
        start_burst(32'h0000_2000, 256, 256);
        wait_done(2000);
        chk("full_aw_len", 64'(last_awlen), 64'hFF);
        chk("full_pops",   64'(pops_cnt - p0), 64'd256);
        chk("full_last",   64'(last_cnt - l0), 64'd1);
        wr_mode = 0;

        // FIFO underrun after 5 words, refilled 10 cycles later
        p0 = pops_cnt;
        start_burst(32'h0000_3000, 16, 5);
        wait_pops(p0 + 5, 100);
        w0 = wv_cnt;
        cyc_wait(10);
        chk("gap_no_pop",     64'(pops_cnt - p0), 64'd5);
        chk("gap_no_w_valid", 64'(wv_cnt - w0),   64'd0);
        push_words(5, 11);
        wait_done(200);
        chk("underrun_pops", 64'(pops_cnt - p0), 64'd16);

        // illegal lengths are dropped
        a0 = aw_hs_cnt;
        start_burst(32'h0000_4000, 0, 0);
        cyc_wait(8);
        start_burst(32'h0000_4100, 300, 0);
        cyc_wait(8);
        chk("illegal_no_aw", 64'(aw_hs_cnt - a0), 64'd0);
        chk("illegal_idle",  64'(wr_ready), 64'd1);

        // start pulsed during the data phase is ignored
        wr_mode = 2;
        a0 = aw_hs_cnt; p0 = pops_cnt;
        start_burst(32'h0000_5000, 32, 32);
        wait_pops(p0 + 3, 200);
        wr_adrs = 32'h0000_5800; wr_len = 10'd4; wr_start = 1'b1;
        cyc_wait(1);
        wr_start = 1'b0;
        wait_done(500);
        chk("busy_one_aw", 64'(aw_hs_cnt - a0), 64'd1);
        chk("busy_pops",   64'(pops_cnt - p0),  64'd32);
        wr_mode = 0;

        // error response
        resp_val = 2'b10;
        e0 = err_cnt; d0 = done_cnt;
        start_burst(32'h0000_6000, 4, 4);
        wait_done(100);
        chk("slverr_flag", 64'(err_cnt - e0), ERR_EN ? 64'd1 : 64'd0);
        resp_val = 2'b00;

        // reset after beat 3 of 8
        p0 = pops_cnt; d0 = done_cnt;
        start_burst(32'h0000_7000, 8, 8);
        wait_pops(p0 + 3, 100);
        axi_rst = 1'b1;
        #1;
        chk("midrst_aw_addr",  64'(m_axi_aw_addr), 64'd0);
        chk("midrst_w_valid",  64'(m_axi_w_valid), 64'd0);
        chk("midrst_wr_ready", 64'(wr_ready),      64'd1);
        cyc_wait(1);
        fifo_q.delete();
        cyc_wait(1);
        axi_rst = 1'b0;
        cyc_wait(20);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        p0 = pops_cnt;
        start_burst(32'h0000_8000, 8, 8);
        wait_done(100);
        chk("post_rst_pops", 64'(pops_cnt - p0), 64'd8);

        // randomized bursts
        aw_mode = 1; wr_mode = 2; rand_empty = 1'b1;
        for (int n = 0; n < 30; n++) begin
            resp_val = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a0 = aw_hs_cnt;
                start_burst($urandom, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(257, 1023)), 0);
                cyc_wait(6);
                chk("rand_illegal_no_aw", 64'(aw_hs_cnt - a0), 64'd0);
            end else begin
                len = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(1, 48));
                p0 = pops_cnt;
                start_burst($urandom & 32'hFFFF_F000, len, len);
                wait_done(len * 12 + 100);
                chk("rand_pops", 64'(pops_cnt - p0), 64'(len));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_master_write.md
# axi_master_write

AXI write-burst master for the DDR3 frame path: on a single user trigger it issues one incrementing 64-bit burst of 1–256 beats to the memory controller. Beat data is pulled from a show-ahead (FWFT) write FIFO, and a one-cycle completion strobe is raised once the B response has been accepted. It is the write-side counterpart of the AXI read master and shares its user-side handshake style (`*_start`, `*_ready`, `*_done`).

## Interface
Parameters:
- `AXI_ID`, default 4'b1111: constant driven on `m_axi_aw_id`.
- `MAX_LEN`, default 256: largest legal `wr_len`.

Ports:
- `axi_clk`  in  1  single clock for all logic.
- `axi_rst`  in  1  asynchronous, active-high reset.
- `m_axi_aw_id`  out  4  = `AXI_ID`.
- `m_axi_aw_addr`  out  32  registered burst start address.
- `m_axi_aw_len`  out  8  registered `wr_len - 1`.
- `m_axi_aw_size`  out  3  constant 3'b011 (8 bytes per beat).
- `m_axi_aw_burst`  out  2  constant 2'b01 (INCR).
- `m_axi_aw_lock`  out  2  constant 0.
- `m_axi_aw_cache`  out  4  constant 4'b0011.
- `m_axi_aw_prot`  out  3  constant 0.
- `m_axi_aw_qos`  out  4  constant 0.
- `m_axi_aw_valid` / `m_axi_aw_ready`  out/in  1  address handshake.
- `m_axi_w_data`  out  64  = `wr_fifo_data`.
- `m_axi_w_strb`  out  8  constant 8'hFF.
- `m_axi_w_last`  out  1  high on the final beat.
- `m_axi_w_valid` / `m_axi_w_ready`  out/in  1  data handshake.
- `m_axi_b_id`  in  4  ignored.
- `m_axi_b_resp`  in  2  write response.
- `m_axi_b_valid` / `m_axi_b_ready`  in/out  1  response handshake.
- `wr_start`  in  1  burst trigger, sampled in IDLE only.
- `wr_adrs`  in  32  burst address.
- `wr_len`  in  10  beat count.
- `wr_ready`  out  1  high when in IDLE.
- `wr_fifo_empty`  in  1  FIFO empty flag.
- `wr_fifo_data`  in  64  FIFO head word (show-ahead).
- `wr_fifo_re`  out  1  FIFO pop.
- `wr_fifo_done`  out  1  one-cycle pulse: burst complete.
- `wr_err`  out  1  one-cycle pulse coincident with `wr_fifo_done` when the response was not OKAY.

## Operation
- States: `S_WR_IDLE`, `S_WA_WAIT`, `S_WA_START`, `S_WA_HOLD`, `S_WD_PROC`, `S_WR_RESP`, `S_WR_DONE`.
- **S_WR_IDLE**
  - Trigger condition: `wr_start` = 1 and 1 ≤ `wr_len` ≤ `MAX_LEN`.
  - On trigger: latch `wr_adrs` into the address register, latch `wr_len - 1` (truncated to 8 bits) into the len register, clear the beat counter, go to `S_WA_WAIT`.
  - A start with an illegal `wr_len` (0 or > `MAX_LEN`) is dropped; the block stays idle.
- **S_WA_WAIT** → `S_WA_START` unconditionally.
- **S_WA_START**: set `aw_valid` = 1, go to `S_WA_HOLD`.
- **S_WA_HOLD**: on `aw_ready`, clear `aw_valid` and go to `S_WD_PROC`. `aw_valid`, `aw_addr` and `aw_len` stay stable until that handshake.
- **S_WD_PROC**
  - `w_valid` = !`wr_fifo_empty` (combinational, only in this state).
  - Beat handshake: `beat` = `w_valid` & `w_ready`; `wr_fifo_re` = `beat`.
  - Beat counter (8-bit) increments on each `beat`.
  - `w_last` = `w_valid` & (counter == len register).
  - A `beat` together with `w_last` moves to `S_WR_RESP`.
  - An empty FIFO stalls the burst with no timeout.
- **S_WR_RESP**: `b_ready` = 1. On `b_valid`, capture the error flag (`b_resp` ≠ 2'b00) and go to `S_WR_DONE`.
- **S_WR_DONE**: `wr_fifo_done` = 1 for one cycle; `wr_err` = captured flag; return to `S_WR_IDLE`.
- W data is never presented before AW is accepted. Only one burst is ever outstanding.
- No 4 KB boundary splitting: the caller guarantees the burst does not cross 4 KB.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - State returns to `S_WR_IDLE`; all registers clear.
  - `aw_valid`, `w_valid`, `w_last`, `b_ready`, `wr_fifo_re`, `wr_fifo_done`, `wr_err` = 0; `wr_ready` = 1; `aw_addr` = 0; `aw_len` = 0.
  - An interrupted burst is abandoned and is not completed after reset.
- Start-to-address latency: start sampled at edge N → `aw_valid` first high in cycle N+3 (after the `S_WA_WAIT` and `S_WA_START` registers).
- Data phase: one beat per cycle when the FIFO is non-empty and `w_ready` = 1. The minimum length of `S_WD_PROC` is `wr_len` cycles.
- Response: `b_ready` rises the cycle after the last beat.
- Completion: `wr_fifo_done` is asserted the cycle after the `b_valid` handshake.
- `wr_ready` is low from the cycle after start through `S_WR_DONE`, and high again in the following cycle. The earliest next start is therefore sampled two cycles after the `b_valid` handshake.
- `wr_start` pulses while busy are ignored.

## Configuration
- Macro: `AXI_WR_BRESP_CHECK_EN`.
- Defined: `b_resp` is evaluated and `wr_err` behaves as described in Operation.
- Undefined: the `b_resp` logic is removed, `wr_err` is tied to 0, and `b_resp` is unused. State flow is identical in both builds.

## Test plan
- **Single beat**: `wr_len`=1, `wr_adrs`=32'h0000_1000, slave always ready → `aw_len`=0; one beat with `w_last`=1; exactly one `wr_fifo_re`; `wr_fifo_done` pulse; `wr_err`=0.
- **Full burst with backpressure**: `wr_len`=256, `w_ready` toggling every cycle → 256 pops; `w_last` only on beat 256; `aw_len`=8'hFF; data order matches the FIFO.
- **FIFO underrun**: `wr_len`=16, FIFO empties after 5 words for 10 cycles → `w_valid`=0 during the gap, no pop, burst resumes and completes with 16 beats.
- **Illegal length and busy start**: `wr_len`=0 → remains idle, `aw_valid` never asserts. `wr_start` pulsed during `S_WD_PROC` → ignored, only one AW handshake.
- **Error response**: `b_resp`=2'b10 → `wr_err`=1 together with `wr_fifo_done` (0 when built without `AXI_WR_BRESP_CHECK_EN`).
- **Reset mid-burst**: `axi_rst` asserted after beat 3 of 8 → all outputs take reset values that cycle, `wr_ready`=1, no `wr_fifo_done`. A fresh start afterwards completes normally.
